// File: rtl/uart_pkg.sv
// UART transmitter shared definitions.
// FSM state encoding and serial line level constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while en is high.
// Ports: clk, reset (sync, active-high), en, bit_end (last-count pulse).
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, stop.
// Ports: clk, reset (sync, active-high), tx_start, data_in,
//   tx_done (1-cycle pulse), tx_serial (idle high).
// Macro UART_PARITY_EN inserts an even-parity bit before stop.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_done,
  output logic                 tx_serial
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 done_q, done_n;
  logic                 serial_n;
  logic                 bit_end;
`ifdef UART_PARITY_EN
  logic                 par_q, par_n;
`endif

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (state != IDLE),
    .bit_end(bit_end)
  );

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    done_n    = 1'b0;
    serial_n  = LINE_IDLE;
`ifdef UART_PARITY_EN
    par_n     = par_q;
`endif
    unique case (state)
      IDLE: begin
        if (tx_start) begin
          state_n   = START;
          shift_n   = data_in;
          bit_cnt_n = '0;
`ifdef UART_PARITY_EN
          par_n     = ^data_in;
`endif
        end
      end
      START: begin
        serial_n = START_LVL;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        serial_n = shift[0];
        if (bit_end) begin
          shift_n = shift >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_n = '0;
`ifdef UART_PARITY_EN
            state_n   = PARITY;
`else
            state_n   = STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        serial_n = par_q;
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        serial_n = STOP_LVL;
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line and done are registered from the current state, so both
  // trail the FSM by one cycle; done needs the extra done_q stage
  // to land on the idle cycle after the stop bit has been on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      done_q    <= 1'b0;
      tx_done   <= 1'b0;
      tx_serial <= LINE_IDLE;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      done_q    <= done_n;
      tx_done   <= done_q;
      tx_serial <= serial_n;
`ifdef UART_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core at CLKS_PER_BIT 1 and 4.
// Directed tables plus randomized traffic against a frame model.
module tb_uart_tx_core;

`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DB = 8;
  localparam int NB = 2 + DB + PB;

  logic clk = 1'b0;
  logic reset, tx_start;
  logic [7:0] data_in;
  logic done1, ser1, done4, ser4;

  always #5 clk = ~clk;

  uart_tx_core #(.CLKS_PER_BIT(1), .DATA_BITS(DB)) dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start),
    .data_in(data_in), .tx_done(done1), .tx_serial(ser1)
  );

  uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(DB)) dut4 (
    .clk(clk), .reset(reset), .tx_start(tx_start),
    .data_in(data_in), .tx_done(done4), .tx_serial(ser4)
  );

  int tests = 0;
  int fails = 0;
  int k = 0;
  int lnch [2] = '{-1, -1};
  logic [7:0] md [2];
  int clks [2] = '{1, 4};

  typedef struct {
    int   off;
    logic ser;
    logic done;
  } vec_t;
  vec_t tbl [$];

  logic cap_ser [0:15];
  logic cap_done [0:15];

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, k, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
    if (PB == 1 && idx == DB + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic s, input logic [7:0] d);
    logic es [2];
    logic ed [2];
    int fl;
    reset = r;
    tx_start = s;
    data_in = d;
    @(posedge clk);
    k++;
    for (int u = 0; u < 2; u++) begin
      fl = NB * clks[u];
      if (r) begin
        lnch[u] = -1;
        ed[u] = 1'b0;
      end else begin
        ed[u] = (lnch[u] >= 0) && (k == lnch[u] + fl + 1);
        if ((lnch[u] < 0 || k >= lnch[u] + fl + 1) && s) begin
          lnch[u] = k;
          md[u] = d;
        end
      end
      if (lnch[u] >= 0 && k >= lnch[u] + 1 && k <= lnch[u] + fl)
        es[u] = frame_bit(md[u], (k - lnch[u] - 1) / clks[u]);
      else
        es[u] = 1'b1;
    end
    #1;
    chk("ser1", ser1, es[0]);
    chk("done1", done1, ed[0]);
    chk("ser4", ser4, es[1]);
    chk("done4", done4, ed[1]);
  endtask

  initial begin
    int first;
    logic [7:0] d1;
    reset = 1'b1;
    tx_start = 1'b0;
    data_in = 8'h00;

    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h55);

    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'($urandom));

`ifdef UART_PARITY_EN
    d1 = 8'h07;
    tbl.push_back('{0, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b0});
    tbl.push_back('{2, 1'b1, 1'b0});
    tbl.push_back('{4, 1'b1, 1'b0});
    tbl.push_back('{5, 1'b0, 1'b0});
    tbl.push_back('{9, 1'b0, 1'b0});
    tbl.push_back('{10, 1'b1, 1'b0});
    tbl.push_back('{11, 1'b1, 1'b0});
    tbl.push_back('{12, 1'b1, 1'b1});
    tbl.push_back('{13, 1'b0, 1'b0});
`else
    d1 = 8'h01;
    tbl.push_back('{0, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b0, 1'b0});
    tbl.push_back('{2, 1'b1, 1'b0});
    tbl.push_back('{3, 1'b0, 1'b0});
    tbl.push_back('{9, 1'b0, 1'b0});
    tbl.push_back('{10, 1'b1, 1'b0});
    tbl.push_back('{11, 1'b1, 1'b1});
    tbl.push_back('{12, 1'b0, 1'b0});
    tbl.push_back('{13, 1'b1, 1'b0});
`endif
    for (int j = 0; j < 16; j++) begin
      step(1'b0, 1'b1, d1);
      cap_ser[j] = ser1;
      cap_done[j] = done1;
    end
    foreach (tbl[i]) begin
      chk($sformatf("tbl_ser[%0d]", tbl[i].off),
          cap_ser[tbl[i].off], tbl[i].ser);
      chk($sformatf("tbl_done[%0d]", tbl[i].off),
          cap_done[tbl[i].off], tbl[i].done);
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00);

    first = -1;
    step(1'b0, 1'b1, 8'hA5);
    for (int j = 1; j <= 60; j++) begin
      step(1'b0, 1'b0, 8'hA5);
      if (done4 && first < 0) first = j;
    end
    chk_int("a5_done_cycle", first, NB * 4 + 1);

    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'hFF);

    step(1'b0, 1'b1, 8'h96);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("rst_mid_ser4", ser4, 1'b1);
    chk("rst_mid_done4", done4, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3A);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
